// File: rtl/alu_issue.sv
// Two-stage issue / write-back wrapper around an external combinational ALU.
// Operands come from an internal register file with forwarding from E.
module alu_issue #(
    parameter int NREG = 8,
    parameter int AW   = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [4:0]    in_op,
    input  logic [AW-1:0] in_rd,
    input  logic [AW-1:0] in_rs,
    input  logic [AW-1:0] in_rt,
    input  logic          in_imm_en,
    input  logic [15:0]   in_imm,
    input  logic          hold,
    output logic [15:0]   alu_a,
    output logic [15:0]   alu_b,
    output logic [4:0]    alu_f,
    input  logic [15:0]   alu_s,
    output logic          wb_valid,
    output logic [AW-1:0] wb_rd,
    output logic [15:0]   wb_data,
    output logic          err_op,
    input  logic [AW-1:0] dbg_addr,
    output logic [15:0]   dbg_data
);

    // Defined opcodes occupy the contiguous range ADD (0) .. NOT (18).
    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_NOT = 5'd18;

    logic [15:0]   rf [NREG];
    logic          ex_valid;
    logic          ex_we;
    logic [AW-1:0] ex_rd;
    logic          wb_valid_q;
    logic          err_q;

    logic          accept;
    logic          op_def;
    logic [15:0]   opnd_a;
    logic [15:0]   opnd_b;

    function automatic logic [15:0] lookup(input logic [AW-1:0] src);
        if (src == '0)
            return 16'h0000;
        if (ex_valid && ex_we && (ex_rd == src))
            return alu_s;
        return rf[src];
    endfunction

    assign in_ready = ~hold;
    assign accept   = in_valid && in_ready;
    assign op_def   = (in_op <= OP_NOT);
    assign opnd_a   = lookup(in_rs);
    assign opnd_b   = in_imm_en ? in_imm : lookup(in_rt);

    // Pulses are masked while frozen so a stale pulse cannot linger across hold.
    assign wb_valid = wb_valid_q & ~hold;
    assign err_op   = err_q & ~hold;
    assign dbg_data = (dbg_addr == '0) ? 16'h0000 : rf[dbg_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                rf[i] <= 16'h0000;
            ex_valid   <= 1'b0;
            ex_we      <= 1'b0;
            ex_rd      <= '0;
            alu_a      <= 16'h0000;
            alu_b      <= 16'h0000;
            alu_f      <= 5'd0;
            wb_valid_q <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= 16'h0000;
            err_q      <= 1'b0;
        end else if (hold) begin
            wb_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wb_valid_q <= ex_valid && ex_we;
            if (ex_valid) begin
                wb_rd   <= ex_rd;
                wb_data <= alu_s;
                if (ex_we)
                    rf[ex_rd] <= alu_s;
            end
            err_q <= accept && !op_def;
            if (accept) begin
                ex_valid <= 1'b1;
                ex_we    <= op_def && (in_rd != '0);
                ex_rd    <= in_rd;
                alu_a    <= opnd_a;
                alu_b    <= opnd_b;
                alu_f    <= op_def ? in_op : OP_ADD;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue.sv
// Randomized bench for alu_issue: architectural (in-order) register model plus
// a one-deep expected write-back slot, with a behavioural ALU driving alu_s.
module tb_alu_issue;

    localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, MUL = 5'd2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_imm_en, hold;
    logic [4:0]  in_op, alu_f;
    logic [2:0]  in_rd, in_rs, in_rt, wb_rd, dbg_addr;
    logic [15:0] in_imm, alu_a, alu_b, alu_s, wb_data, dbg_data;
    logic        wb_valid, err_op;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] arch [8];
    logic [15:0] comm [8];
    logic        pend_v, pend_we;
    logic [2:0]  pend_rd;
    logic [15:0] pend_data;

    alu_issue #(.NREG(8), .AW(3)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rd(in_rd), .in_rs(in_rs), .in_rt(in_rt),
        .in_imm_en(in_imm_en), .in_imm(in_imm), .hold(hold),
        .alu_a(alu_a), .alu_b(alu_b), .alu_f(alu_f), .alu_s(alu_s),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .err_op(err_op),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_fn(input logic [4:0] f, input logic [15:0] a, input logic [15:0] b);
        case (f)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a * b;
            5'd3:  return (b == 0) ? 16'h0 : a / b;
            5'd4:  return (b == 0) ? 16'h0 : a % b;
            5'd5:  return a & b;
            5'd6:  return a | b;
            5'd7:  return a ^ b;
            5'd8:  return a << b[3:0];
            5'd9:  return a >> b[3:0];
            5'd10: return {15'd0, (a != 0) && (b != 0)};
            5'd11: return {15'd0, (a != 0) || (b != 0)};
            5'd12: return {15'd0, a == b};
            5'd13: return {15'd0, a != b};
            5'd14: return {15'd0, a < b};
            5'd15: return {15'd0, a > b};
            5'd16: return {15'd0, a <= b};
            5'd17: return {15'd0, a >= b};
            5'd18: return ~a;
            default: return 16'h0;
        endcase
    endfunction

    assign alu_s = alu_fn(alu_f, alu_a, alu_b);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            arch[i] = 16'h0;
            comm[i] = 16'h0;
        end
        pend_v    = 1'b0;
        pend_we   = 1'b0;
        pend_rd   = 3'd0;
        pend_data = 16'h0;
    endtask

    // One clock: drive at negedge, check just after the rising edge.
    task automatic step(input logic v, input logic [4:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [2:0] rt, input logic ie,
                        input logic [15:0] imm, input logic h);
        logic [15:0] a, b, f_exp;
        logic        def;
        @(negedge clk);
        in_valid  = v;
        in_op     = op;
        in_rd     = rd;
        in_rs     = rs;
        in_rt     = rt;
        in_imm_en = ie;
        in_imm    = imm;
        hold      = h;
        dbg_addr  = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        if (h) begin
            check("in_ready_hold", {31'd0, in_ready}, 32'd0);
            check("wb_valid_hold", {31'd0, wb_valid}, 32'd0);
            check("err_op_hold", {31'd0, err_op}, 32'd0);
        end else begin
            check("in_ready", {31'd0, in_ready}, 32'd1);
            if (pend_v && pend_we) begin
                check("wb_valid", {31'd0, wb_valid}, 32'd1);
                check("wb_rd", {29'd0, wb_rd}, {29'd0, pend_rd});
                check("wb_data", {16'd0, wb_data}, {16'd0, pend_data});
                comm[pend_rd] = pend_data;
            end else begin
                check("wb_valid_idle", {31'd0, wb_valid}, 32'd0);
            end
            pend_v = 1'b0;
            if (v) begin
                a     = arch[rs];
                b     = ie ? imm : arch[rt];
                def   = (op < 5'd19);
                f_exp = {11'd0, def ? op : ADD};
                check("alu_a", {16'd0, alu_a}, {16'd0, a});
                check("alu_b", {16'd0, alu_b}, {16'd0, b});
                check("alu_f", {27'd0, alu_f}, {16'd0, f_exp});
                check("err_op", {31'd0, err_op}, {31'd0, !def});
                pend_v    = 1'b1;
                pend_we   = def && (rd != 3'd0);
                pend_rd   = rd;
                pend_data = alu_fn(f_exp[4:0], a, b);
                if (pend_we)
                    arch[rd] = pend_data;
            end else begin
                check("err_op_idle", {31'd0, err_op}, 32'd0);
            end
        end
        check("dbg_data", {16'd0, dbg_data}, {16'd0, comm[dbg_addr]});
    endtask

    task automatic idle();
        step(1'b0, ADD, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [2:0] r, input logic [15:0] exp);
        dbg_addr = r;
        #1;
        check(tag, {16'd0, dbg_data}, {16'd0, exp});
    endtask

    task automatic rand_step(input int hold_pct);
        logic [4:0] op;
        op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(19, 31)) : 5'($urandom_range(0, 18));
        step(($urandom_range(0, 9) < 8), op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
             3'($urandom_range(0, 7)), $urandom_range(0, 1) == 1, 16'($urandom),
             ($urandom_range(0, 99) < hold_pct));
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = ADD; in_rd = 0; in_rs = 0; in_rt = 0;
        in_imm_en = 1'b0; in_imm = 16'h0; hold = 1'b0; dbg_addr = 3'd0;
        model_reset();
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("rst_alu_f", {27'd0, alu_f}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Immediate loads
        step(1'b1, ADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'd5, 1'b0);
        step(1'b1, ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'd7, 1'b0);
        idle();
        peek("r2_is_7", 3'd2, 16'd7);

        // Back-to-back dependent instructions
        step(1'b1, MUL, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0);
        step(1'b1, SUB, 3'd4, 3'd3, 3'd1, 1'b0, 16'h0, 1'b0);
        step(1'b1, SUB, 3'd5, 3'd0, 3'd0, 1'b1, 16'd1, 1'b0);
        idle();
        peek("r3_is_35", 3'd3, 16'd35);
        peek("r4_is_30", 3'd4, 16'd30);
        peek("r5_is_ffff", 3'd5, 16'hFFFF);

        // r0 writes are dropped and never forwarded
        step(1'b1, ADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'd9, 1'b0);
        step(1'b1, ADD, 3'd6, 3'd0, 3'd0, 1'b1, 16'd1, 1'b0);
        idle();
        peek("r0_is_0", 3'd0, 16'd0);
        peek("r6_is_1", 3'd6, 16'd1);

        // Hold with an instruction in E; presented inputs must be ignored
        step(1'b1, ADD, 3'd7, 3'd1, 3'd0, 1'b1, 16'd100, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b1, ADD, 3'd2, 3'd0, 3'd0, 1'b1, 16'hBEEF, 1'b1);
        idle();
        peek("r7_is_105", 3'd7, 16'd105);
        peek("r2_kept", 3'd2, 16'd7);

        // Undefined opcode then a normal dependent instruction
        step(1'b1, 5'h1F, 3'd3, 3'd1, 3'd2, 1'b0, 16'h0, 1'b0);
        step(1'b1, ADD, 3'd4, 3'd3, 3'd0, 1'b1, 16'd1, 1'b0);
        idle();
        peek("r3_unchanged", 3'd3, 16'd35);
        peek("r4_is_36", 3'd4, 16'd36);

        for (int i = 0; i < 400; i++)
            rand_step(20);

        // Reset between edges with work in E and write-back
        step(1'b1, ADD, 3'd1, 3'd2, 3'd3, 1'b0, 16'h0, 1'b0);
        step(1'b1, SUB, 3'd2, 3'd1, 3'd0, 1'b1, 16'd3, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        check("mid_rst_wb_rd", {29'd0, wb_rd}, 32'd0);
        check("mid_rst_wb_data", {16'd0, wb_data}, 32'd0);
        check("mid_rst_alu_a", {16'd0, alu_a}, 32'd0);
        check("mid_rst_alu_b", {16'd0, alu_b}, 32'd0);
        check("mid_rst_alu_f", {27'd0, alu_f}, 32'd0);
        check("mid_rst_err_op", {31'd0, err_op}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int r = 0; r < 8; r++)
            peek("post_rst_reg", 3'(r), 16'h0);

        for (int i = 0; i < 100; i++)
            rand_step(10);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
# alu_issue

Two-stage issue/write-back stage wrapped around the combinational ALU. It accepts decoded instructions over a valid/ready handshake and reads operands from an internal register file. It drives the ALU's `a`/`b`/`f` inputs from pipeline registers, captures the ALU result `s`, and writes it back to the register file. Results from the instruction in execute are forwarded, so back-to-back dependent instructions issue without stalls.

## Interface
- `NREG`, 8, number of 16-bit registers; r0 reads as zero and ignores writes.
- `AW`, 3, register address width, equal to log2(`NREG`).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  stage can accept; equals `~hold`.
- `in_op`  in  5  opcode, using the `define.v` opcode macros (`ADD`…`NOT`).
- `in_rd`, `in_rs`, `in_rt`  in  AW each  destination, source A, source B.
- `in_imm_en`  in  1  when 1, operand B comes from `in_imm` instead of `rt`.
- `in_imm`  in  16  immediate value.
- `hold`  in  1  freezes the pipeline.
- `alu_a`, `alu_b`  out  16  registered operands to the ALU.
- `alu_f`  out  5  registered opcode to the ALU.
- `alu_s`  in  16  ALU result, combinational from `alu_a`/`alu_b`/`alu_f`.
- `wb_valid`  out  1  one-cycle pulse per completed write-back.
- `wb_rd`  out  AW  register written.
- `wb_data`  out  16  value written.
- `err_op`  out  1  one-cycle pulse when an undefined opcode is accepted.
- `dbg_addr`  in  AW  debug read address.
- `dbg_data`  out  16  combinational read of the register file; r0 reads 0.

## Operation
- Accept: an instruction is accepted on a rising edge where `in_valid && in_ready`.
- Operand A: value of `rs`.
- Operand B: `in_imm` if `in_imm_en`, else the value of `rt`.
- Operand lookup order:
  - r0 gives 0;
  - else, if E holds a valid writing instruction with `ex_rd == src`, `alu_s` is forwarded;
  - else the register file value is used.
- E stage (registers `ex_valid`, `alu_a`, `alu_b`, `alu_f`, `ex_rd`, `ex_we`) loads on accept. With no accept and `hold` = 0, it loads `ex_valid` = 0 and the operand/opcode registers keep their values.
- Write enable `ex_we`: 1 for the 19 defined opcodes with `rd` ≠ 0.
- Undefined opcode:
  - the instruction is accepted with `ex_we` = 0;
  - `alu_f` is forced to `ADD`;
  - `err_op` pulses on the cycle after acceptance.
- Write-back, on an edge with `hold` = 0 and `ex_valid` = 1:
  - `wb_valid <= ex_we`, `wb_rd <= ex_rd`, `wb_data <= alu_s`;
  - if `ex_we`, the register file is written in the same edge.
- Arithmetic: all values are 16-bit; `MUL` is truncated to the low 16 bits; logical and compare ops produce 0 or 1. The ALU defines these; this stage passes `alu_s` through unchanged.
- `hold` = 1:
  - `in_ready` = 0;
  - E, the write-back registers and the register file are unchanged;
  - `wb_valid` and `err_op` are forced to 0 during hold.
  - The in-flight E instruction completes on the first edge after `hold` falls.

## Timing
- Reset (async on `rst_n` = 0): all registers, the register file, `ex_valid`, `alu_a`, `alu_b`, `alu_f`, `wb_valid`, `wb_rd`, `wb_data` and `err_op` go to 0. `in_ready` follows `~hold` even during reset.
- Latency:
  - accept at edge N → `alu_a`/`alu_b`/`alu_f` valid after N;
  - `wb_valid` and the register file updated at edge N+1;
  - the value is readable via `dbg_data` after N+1.
- Throughput: one instruction per cycle, with no dependency stalls.
- Simultaneous events:
  - An instruction accepted at edge N+1 that reads the `rd` written at N+1 gets the forwarded `alu_s`, which is the same value.
  - An instruction with `rs == rt == ex_rd` forwards both operands.
  - `ex_rd == 0` is never forwarded.
- Reset mid-operation: in-flight E and write-back instructions are discarded, with no partial write.

## Test plan
- After reset: `ADD` r1 = r0 + imm 5 (`in_imm_en` = 1), then `ADD` r2 = r0 + imm 7 → write-backs (1, 5) and (2, 7) on consecutive cycles; `dbg_data`(r2) = 7.
- Forwarding: with r1 = 5 and r2 = 7:
  - `MUL` r3 = r1 × r2 issued back-to-back with `SUB` r4 = r3 − r1 → r3 = 35, r4 = 30;
  - `SUB` r5 = r0 − imm 1 → r5 = 0xFFFF.
- Writes to r0: `ADD` r0 = r0 + imm 9 → `wb_valid` = 0 and `dbg_data`(r0) = 0. A following `ADD` r6 = r0 + imm 1 → r6 = 1 (no forwarding from r0).
- `hold` asserted for 3 cycles with an instruction in E:
  - `in_ready` = 0 and no `wb_valid` during hold;
  - the result is written exactly once, on the first edge after release;
  - inputs presented during hold are not accepted.
- Undefined opcode 5'h1F with `rd` = 3 → `err_op` pulse, no write-back, r3 unchanged; the next instruction proceeds normally.
- Assert `rst_n` = 0 mid-stream, between edges, with instructions in E and write-back → all outputs 0 immediately, `dbg_data`(any) = 0 after release.
